// File: rtl/register_access_sequencer_if.sv
// Byte-level bus handshake between the I2C slave byte engine and the
// register access sequencer.
//   bus_start : 1-cycle pulse, (re)start addressed to this device
//   bus_rw    : direction sampled with bus_start (0 = write, 1 = read)
//   bus_stop  : 1-cycle pulse, stop condition
//   rx_valid  : received write byte valid
//   rx_data   : received write byte
//   rx_ready  : sequencer accepts a byte this cycle
//   tx_ack    : 1-cycle pulse, master acked the current read byte
//   tx_data   : byte to transmit on read
interface register_access_sequencer_if;
    logic       bus_start;
    logic       bus_rw;
    logic       bus_stop;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_ack;
    logic [7:0] tx_data;

    modport master (
        output bus_start, bus_rw, bus_stop, rx_valid, rx_data, tx_ack,
        input  rx_ready, tx_data
    );

    modport slave (
        input  bus_start, bus_rw, bus_stop, rx_valid, rx_data, tx_ack,
        output rx_ready, tx_data
    );
endinterface

// File: rtl/register_access_sequencer.sv
// Sequences bus bytes into register writes: the first write byte after a
// start sets the register pointer, each later byte becomes a one-cycle
// register write. Read bytes are served from the register image at the
// pointer. Auto-increment follows MODE1.AI.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   bus                   byte handshake (slave side)
//   ai_enable             MODE1[5] auto-increment
//   sleep                 MODE1[4] sleep (gates PRE_SCALE writes)
//   register_blob         register image [0:2047], byte n = bits [n*8 +: 8]
//   write_register_id     write address
//   write_register_value  write data
//   write_enable          1-cycle write strobe
//   pointer               current register pointer
module register_access_sequencer #(
    parameter logic [7:0] LED_LAST_ADDR = 8'h45,
    parameter logic [7:0] ALL_LED_BASE  = 8'hFA,
    parameter logic [7:0] PRESCALE_ADDR = 8'hFE
) (
    input  logic                          clk,
    input  logic                          rst,
    register_access_sequencer_if.slave    bus,
    input  logic                          ai_enable,
    input  logic                          sleep,
    input  logic [0:2047]                 register_blob,
    output logic [7:0]                    write_register_id,
    output logic [7:0]                    write_register_value,
    output logic                          write_enable,
    output logic [7:0]                    pointer
);

    typedef enum logic [1:0] {IDLE, PTR, DATA, READ} state_t;

    state_t     state, next_state;
    logic       ready;
    logic       take;
    logic [7:0] ptr_adv;
    logic [7:0] rd_cur;
    logic [7:0] rd_adv;

    function automatic logic is_reserved(input logic [7:0] a);
        return ((a > LED_LAST_ADDR) && (a < ALL_LED_BASE)) || (a == 8'hFF);
    endfunction

    function automatic logic [7:0] blob_byte(input logic [7:0] a);
        if (is_reserved(a))
            return 8'h00;
        return register_blob[{a, 3'b000} +: 8];
    endfunction

    // Wrap points: end of LED block, PRE_SCALE and 8'hFF all return to 0.
    function automatic logic [7:0] ai_next(input logic [7:0] a);
        if ((a == LED_LAST_ADDR) || (a == 8'hFE) || (a == 8'hFF))
            return 8'h00;
        return a + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // A start in the same cycle as a byte discards the byte.
    always_comb begin
        ready      = (state == PTR) || (state == DATA);
        take       = bus.rx_valid && ready && !bus.bus_start;
        ptr_adv    = ai_enable ? ai_next(pointer) : pointer;
        rd_cur     = blob_byte(pointer);
        rd_adv     = blob_byte(ptr_adv);
        next_state = state;
        if (bus.bus_start)
            next_state = bus.bus_rw ? READ : PTR;
        else if (bus.bus_stop)
            next_state = IDLE;
        else if (take && (state == PTR))
            next_state = DATA;
    end

    assign bus.rx_ready = ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pointer              <= '0;
            write_enable         <= 1'b0;
            write_register_id    <= '0;
            write_register_value <= '0;
            bus.tx_data          <= '0;
        end else begin
            write_enable <= 1'b0;
            if (take && (state == PTR)) begin
                pointer <= bus.rx_data;
            end else if (take && (state == DATA)) begin
                if (!is_reserved(pointer) && !((pointer == PRESCALE_ADDR) && !sleep)) begin
                    write_enable         <= 1'b1;
                    write_register_id    <= pointer;
                    write_register_value <= bus.rx_data;
                end
                pointer <= ptr_adv;
            end else if ((state == READ) && bus.tx_ack && !bus.bus_start) begin
                pointer     <= ptr_adv;
                bus.tx_data <= rd_adv;
            end
            if (bus.bus_start && bus.bus_rw)
                bus.tx_data <= rd_cur;
        end
    end

endmodule

// File: tb/tb_register_access_sequencer.sv
module tb_register_access_sequencer;

    logic          clk;
    logic          rst;
    logic          ai_enable;
    logic          sleep;
    logic [0:2047] register_blob;
    logic [7:0]    write_register_id;
    logic [7:0]    write_register_value;
    logic          write_enable;
    logic [7:0]    pointer;

    int checks;
    int errors;

    register_access_sequencer_if bus ();

    register_access_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus),
        .ai_enable            (ai_enable),
        .sleep                (sleep),
        .register_blob        (register_blob),
        .write_register_id    (write_register_id),
        .write_register_value (write_register_value),
        .write_enable         (write_enable),
        .pointer              (pointer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_w();
        bus.bus_start = 1'b1;
        bus.bus_rw    = 1'b0;
        cyc();
        bus.bus_start = 1'b0;
    endtask

    task automatic start_r();
        bus.bus_start = 1'b1;
        bus.bus_rw    = 1'b1;
        cyc();
        bus.bus_start = 1'b0;
        bus.bus_rw    = 1'b0;
    endtask

    task automatic stop();
        bus.bus_stop = 1'b1;
        cyc();
        bus.bus_stop = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        cyc();
        bus.rx_valid = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic [7:0] id, input logic [7:0] val);
        chk({tag, "_we"}, write_enable, 1'b1);
        chk({tag, "_id"}, write_register_id, id);
        chk({tag, "_val"}, write_register_value, val);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst           = 1'b1;
        ai_enable     = 1'b0;
        sleep         = 1'b0;
        register_blob = '0;
        register_blob[8'h42*8 +: 8] = 8'hDE;
        register_blob[8'h43*8 +: 8] = 8'h4D;
        register_blob[8'h50*8 +: 8] = 8'h99;
        bus.bus_start = 1'b0;
        bus.bus_rw    = 1'b0;
        bus.bus_stop  = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.tx_ack    = 1'b0;
        cyc();
        cyc();

        // Reset values
        chk("rst_ptr", pointer, 8'h00);
        chk("rst_we", write_enable, 1'b0);
        chk("rst_id", write_register_id, 8'h00);
        chk("rst_val", write_register_value, 8'h00);
        chk("rst_tx", bus.tx_data, 8'h00);
        chk("rst_rdy", bus.rx_ready, 1'b0);
        rst = 1'b0;
        cyc();

        // 1: pointer byte then one write, AI off
        start_w();
        chk("t1_rdy", bus.rx_ready, 1'b1);
        send(8'h00);
        chk("t1_ptr_nowr", write_enable, 1'b0);
        send(8'hBB);
        chk_wr("t1", 8'h00, 8'hBB);
        chk("t1_ptr", pointer, 8'h00);
        cyc();
        chk("t1_we_one", write_enable, 1'b0);
        stop();
        chk("t1_idle_rdy", bus.rx_ready, 1'b0);

        // 2: AI, back-to-back burst through end of LED block
        ai_enable = 1'b1;
        start_w();
        send(8'h42);
        chk("t2_ptr", pointer, 8'h42);
        send(8'hDE);
        chk_wr("t2a", 8'h42, 8'hDE);
        send(8'h4D);
        chk_wr("t2b", 8'h43, 8'h4D);
        send(8'hBE);
        chk_wr("t2c", 8'h44, 8'hBE);
        send(8'hEF);
        chk_wr("t2d", 8'h45, 8'hEF);
        chk("t2_wrap", pointer, 8'h00);
        stop();

        // 3: wrap from LED_LAST_ADDR
        start_w();
        send(8'h45);
        send(8'h11);
        chk_wr("t3a", 8'h45, 8'h11);
        send(8'h22);
        chk_wr("t3b", 8'h00, 8'h22);
        chk("t3_ptr", pointer, 8'h01);
        stop();

        // 4: suppression - reserved, PRE_SCALE awake/asleep, 8'hFF
        ai_enable = 1'b0;
        start_w();
        send(8'h50);
        send(8'hAA);
        chk("t4_resv_we", write_enable, 1'b0);
        chk("t4_resv_ptr", pointer, 8'h50);
        stop();
        start_w();
        send(8'hFE);
        send(8'h1E);
        chk("t4_pre_awake", write_enable, 1'b0);
        stop();
        sleep = 1'b1;
        start_w();
        send(8'hFE);
        send(8'h1E);
        chk_wr("t4_pre_sleep", 8'hFE, 8'h1E);
        stop();
        sleep = 1'b0;
        ai_enable = 1'b1;
        start_w();
        send(8'hFF);
        send(8'h77);
        chk("t4_ff_we", write_enable, 1'b0);
        chk("t4_ff_ptr", pointer, 8'h00);
        stop();

        // 5: restart read with AI
        start_w();
        send(8'h42);
        start_r();
        chk("t5_rdy", bus.rx_ready, 1'b0);
        chk("t5_tx0", bus.tx_data, 8'hDE);
        bus.tx_ack = 1'b1;
        cyc();
        bus.tx_ack = 1'b0;
        chk("t5_tx1", bus.tx_data, 8'h4D);
        chk("t5_ptr", pointer, 8'h43);
        stop();

        // Reserved address reads as zero
        ai_enable = 1'b0;
        start_w();
        send(8'h50);
        start_r();
        chk("rd_resv", bus.tx_data, 8'h00);
        stop();

        // Start with a concurrent byte: byte dropped
        start_w();
        send(8'h10);
        bus.rx_valid  = 1'b1;
        bus.rx_data   = 8'h33;
        bus.bus_start = 1'b1;
        cyc();
        bus.rx_valid  = 1'b0;
        bus.bus_start = 1'b0;
        chk("st_acc_we", write_enable, 1'b0);
        chk("st_acc_ptr", pointer, 8'h10);
        send(8'h20);
        chk("st_acc_newptr", pointer, 8'h20);
        stop();

        // Stop with a concurrent byte: byte processed, then idle
        ai_enable = 1'b1;
        start_w();
        send(8'h05);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h66;
        bus.bus_stop = 1'b1;
        cyc();
        bus.rx_valid = 1'b0;
        bus.bus_stop = 1'b0;
        chk_wr("sp_acc", 8'h05, 8'h66);
        chk("sp_acc_rdy", bus.rx_ready, 1'b0);
        chk("sp_acc_ptr", pointer, 8'h06);

        // tx_ack outside READ is ignored
        bus.tx_ack = 1'b1;
        cyc();
        bus.tx_ack = 1'b0;
        chk("ack_idle_ptr", pointer, 8'h06);

        // 6: reset during the strobe cycle
        ai_enable = 1'b0;
        start_w();
        send(8'h30);
        send(8'h77);
        rst = 1'b1;
        #1;
        chk("t6_we", write_enable, 1'b0);
        chk("t6_ptr", pointer, 8'h00);
        chk("t6_rdy", bus.rx_ready, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("t6_idle", bus.rx_ready, 1'b0);
        chk("t6_we_after", write_enable, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
